easyobv_instr_seq: RTL and testbench

// - Upstream feeder for the traffic generator's instruction stream.
// - Stores a program of up to DEPTH instructions, loaded over an AXI-Stream port.
// - On start, replays the program to instr_* LOOPS times; LOOPS=0 means forever.
// - Allows a traffic pattern to be loaded once and repeated with no host traffic.

---
 rtl/easyobv_seq_pkg.sv | 14 +
 rtl/easyobv_skid_buf.sv | 37 +++
 rtl/easyobv_instr_seq.sv | 141 ++++++++++++++
 tb/tb_easyobv_instr_seq.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/easyobv_seq_pkg.sv
// easyobv_seq_pkg: sequencer state encoding and first-beat latency (EASYOBV_INSTR_SEQ_SKID_EN adds one cycle)
package easyobv_seq_pkg;
    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_ARMED = 2'd1,
        S_PLAY  = 2'd2,
        S_DONE  = 2'd3
    } seq_state_e;
`ifdef EASYOBV_INSTR_SEQ_SKID_EN
    localparam int FIRST_LAT_C = 3;
`else
    localparam int FIRST_LAT_C = 2;
`endif
endpackage

// File: rtl/easyobv_skid_buf.sv
// easyobv_skid_buf: 2-entry skid buffer; s_ready comes from a register, never from m_ready
module easyobv_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [WIDTH-1:0] s_data,
    output logic             s_ready,
    output logic             held,
    output logic             m_valid,
    output logic [WIDTH-1:0] m_data,
    input  logic             m_ready
);
    logic             sk_valid;
    logic [WIDTH-1:0] sk_data;

    assign s_ready = !sk_valid;
    assign held    = sk_valid;

    // advance the output when it is free or draining, otherwise park the incoming word in the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
            sk_valid <= 1'b0;
            sk_data  <= '0;
        end else if (m_ready || !m_valid) begin
            m_valid  <= sk_valid || s_valid;
            m_data   <= sk_valid ? sk_data : s_data;
            sk_valid <= 1'b0;
        end else if (s_valid && !sk_valid) begin
            sk_valid <= 1'b1;
            sk_data  <= s_data;
        end
    end
endmodule

// File: rtl/easyobv_instr_seq.sv
// easyobv_instr_seq: loads a program over AXI-Stream and replays it LOOPS times (0 = forever); EASYOBV_INSTR_SEQ_SKID_EN inserts an output skid buffer
module easyobv_instr_seq
    import easyobv_seq_pkg::*;
#(
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 64,
    parameter int LOOP_BITS   = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [INSTR_WIDTH-1:0]       prog_tdata,
    input  logic                         prog_tvalid,
    output logic                         prog_tready,
    input  logic                         prog_tlast,
    input  logic                         start,
    input  logic                         stop,
    input  logic [LOOP_BITS-1:0]         loops,
    output logic [INSTR_WIDTH-1:0]       instr_tdata,
    output logic                         instr_tvalid,
    input  logic                         instr_tready,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   prog_len,
    output logic [LOOP_BITS-1:0]         loop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 1);

    seq_state_e             state, state_nx;
    logic [INSTR_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]          rd_ptr;
    logic [PW-1:0]          last_idx;
    logic [LOOP_BITS-1:0]   loops_q, iss_cnt;
    logic [INSTR_WIDTH:0]   rd_data;
    logic drain, drain_clr, rd_valid, rd_fwd, idle, o_last;
    logic prog_hs, out_hs, start_ok, halt, more, ren, rd_last, fin, wipe, ld_wr;

    assign last_idx = prog_len - PW'(1);
    assign rd_last  = PW'(rd_ptr) == last_idx;
    assign prog_hs  = prog_tvalid && prog_tready;
    assign ld_wr    = state == S_LOAD && prog_hs && prog_len != PW'(DEPTH);
    assign out_hs   = instr_tvalid && instr_tready;
    assign start_ok = start && !clear && (state == S_ARMED || state == S_DONE);
    assign halt     = stop || clear || drain || drain_clr;
    assign more     = loops_q == '0 || iss_cnt != loops_q;
    assign ren      = state == S_PLAY && !halt && more && (!rd_valid || rd_fwd);
    assign fin      = out_hs && o_last && loops_q != '0 && !(loop_cnt + LOOP_BITS'(1) < loops_q);
    assign wipe     = state == S_PLAY ? (clear || drain_clr) && idle : clear;
    assign busy     = state == S_PLAY;

`ifdef EASYOBV_INSTR_SEQ_SKID_EN
    logic                 sk_ready, sk_held;
    logic [INSTR_WIDTH:0] o_data;
    easyobv_skid_buf #(.WIDTH(INSTR_WIDTH + 1)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (rd_valid),
        .s_data  (rd_data),
        .s_ready (sk_ready),
        .held    (sk_held),
        .m_valid (instr_tvalid),
        .m_data  (o_data),
        .m_ready (instr_tready)
    );
    assign rd_fwd = sk_ready;
    assign idle   = !rd_valid && !sk_held && (!instr_tvalid || instr_tready);
    assign {o_last, instr_tdata} = o_data;
`else
    assign rd_fwd       = instr_tready;
    assign idle         = !rd_valid || instr_tready;
    assign instr_tvalid = rd_valid;
    assign {o_last, instr_tdata} = rd_data;
`endif

    // next state: clear beats everything, start leaves ARMED/DONE, stop/clear wait for the presented beat
    always_comb begin
        state_nx = state;
        if (wipe) state_nx = S_LOAD;
        else if (state == S_LOAD) state_nx = prog_hs && prog_tlast ? S_ARMED : S_LOAD;
        else if (start_ok) state_nx = S_PLAY;
        else if (state == S_PLAY) state_nx = fin ? S_DONE : ((stop || drain) && idle ? S_ARMED : S_PLAY);
    end

    // program RAM write port; beats past DEPTH are accepted but never stored
    always_ff @(posedge clk) begin
        if (ld_wr) mem[prog_len[AW-1:0]] <= prog_tdata;
    end

    // control state, read pipeline and pass accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            prog_tready <= 1'b0;
            prog_len    <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
            loop_cnt    <= '0;
            loops_q     <= '0;
            iss_cnt     <= '0;
            rd_ptr      <= '0;
            drain       <= 1'b0;
            drain_clr   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_nx;
            prog_tready <= state_nx == S_LOAD;
            drain       <= state == S_PLAY && state_nx == S_PLAY && (drain || stop);
            drain_clr   <= state == S_PLAY && state_nx == S_PLAY && (drain_clr || clear);
            if (ld_wr) begin
                prog_len <= prog_len + PW'(1);
                if (prog_len == PW'(DEPTH - 1) && !prog_tlast) overflow <= 1'b1;
            end
            if (start_ok) begin
                loops_q  <= loops;
                loop_cnt <= '0;
                iss_cnt  <= '0;
                rd_ptr   <= '0;
                done     <= 1'b0;
            end
            if (ren) begin
                rd_ptr   <= rd_last ? '0 : rd_ptr + AW'(1);
                rd_valid <= 1'b1;
                rd_data  <= {rd_last, mem[rd_ptr]};
                if (rd_last) iss_cnt <= iss_cnt + LOOP_BITS'(1);
            end else if (rd_fwd) begin
                rd_valid <= 1'b0;
            end
            if (state == S_PLAY && out_hs && o_last) loop_cnt <= loop_cnt + LOOP_BITS'(1);
            if (fin) done <= 1'b1;
            if (wipe) begin
                prog_len <= '0;
                overflow <= 1'b0;
                done     <= 1'b0;
                loop_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_easyobv_instr_seq.sv
// tb_easyobv_instr_seq: directed table-driven bench for the instruction sequencer (DEPTH=8)
module tb_easyobv_instr_seq;
    localparam int W  = 32;
    localparam int D  = 8;
    localparam int LB = 16;

    logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0, start = 1'b0, stop = 1'b0;
    logic          prog_tvalid = 1'b0, prog_tlast = 1'b0, instr_tready = 1'b0;
    logic [W-1:0]  prog_tdata = '0;
    logic [LB-1:0] loops = '0;
    logic          prog_tready, instr_tvalid, busy, done, overflow;
    logic [W-1:0]  instr_tdata;
    logic [3:0]    prog_len;
    logic [LB-1:0] loop_cnt;

    int checks = 0;
    int failures = 0;

    easyobv_instr_seq #(.INSTR_WIDTH(W), .DEPTH(D), .LOOP_BITS(LB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .prog_tdata   (prog_tdata),
        .prog_tvalid  (prog_tvalid),
        .prog_tready  (prog_tready),
        .prog_tlast   (prog_tlast),
        .start        (start),
        .stop         (stop),
        .loops        (loops),
        .instr_tdata  (instr_tdata),
        .instr_tvalid (instr_tvalid),
        .instr_tready (instr_tready),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .prog_len     (prog_len),
        .loop_cnt     (loop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n_load;
        int lp;
        int exp_len;
        bit exp_ovf;
        int exp_beats;
        int exp_lcnt;
    } vec_t;

    vec_t tbl [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int n, input logic [W-1:0] base);
        int t;
        for (int i = 0; i < n; i++) begin
            prog_tvalid = 1'b1;
            prog_tdata  = base + W'(i);
            prog_tlast  = (i == n - 1);
            t = 0;
            while (!prog_tready && t < 20) begin
                tick();
                t++;
            end
            if (!prog_tready) chk("load_ready_timeout", prog_tready, 1);
            tick();
        end
        prog_tvalid = 1'b0;
        prog_tlast  = 1'b0;
    endtask

    task automatic pulse_start(input logic [LB-1:0] n);
        start = 1'b1;
        loops = n;
        tick();
        start = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, beats, cyc, bad;
        logic [W-1:0] base, prev_d;
        logic prev_v, prev_r;
        tbl[0] = '{4, 3, 4, 1'b0, 12, 3};
        tbl[1] = '{10, 1, 8, 1'b1, 8, 1};
        tbl[2] = '{1, 5, 1, 1'b0, 5, 5};
        tbl[3] = '{8, 2, 8, 1'b0, 16, 2};
        tbl[4] = '{3, 2, 3, 1'b0, 6, 2};

        tick();
        tick();
        chk("rst_prog_tready", prog_tready, 0);
        chk("rst_tvalid", instr_tvalid, 0);
        chk("rst_tdata", instr_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_prog_len", prog_len, 0);
        chk("rst_loop_cnt", loop_cnt, 0);
        rst_n = 1'b1;
        chk("rel_prog_tready_low", prog_tready, 0);
        tick();
        chk("rel_prog_tready_high", prog_tready, 1);

        for (int r = 0; r < 5; r++) begin
            base = 32'hA000_0000 + W'(r << 8);
            load(tbl[r].n_load, base);
            chk("row_prog_len", prog_len, tbl[r].exp_len);
            chk("row_overflow", overflow, tbl[r].exp_ovf);
            chk("row_armed_tready", prog_tready, 0);
            instr_tready = 1'b1;
            pulse_start(LB'(tbl[r].lp));
            lat = 1;
            while (!instr_tvalid && lat < 20) begin
                tick();
                lat++;
            end
            chk("row_latency", lat, 2);
            beats = 0;
            while (instr_tvalid && beats < 100) begin
                chk("row_data", instr_tdata, base + W'(beats % tbl[r].exp_len));
                beats++;
                tick();
            end
            chk("row_beats", beats, tbl[r].exp_beats);
            chk("row_done", done, 1);
            chk("row_busy", busy, 0);
            chk("row_loop_cnt", loop_cnt, tbl[r].exp_lcnt);
            clear = 1'b1;
            tick();
            clear = 1'b0;
            chk("row_clear_len", prog_len, 0);
            chk("row_clear_done", done, 0);
            chk("row_clear_tready", prog_tready, 1);
        end

        base = 32'hB000_0000;
        load(4, base);
        instr_tready = 1'b0;
        pulse_start(3);
        beats = 0;
        cyc = 0;
        prev_v = 1'b0;
        prev_r = 1'b0;
        prev_d = '0;
        while (beats < 12 && cyc < 500) begin
            if (prev_v && !prev_r) begin
                chk("stall_valid_held", instr_tvalid, 1);
                chk("stall_data_held", instr_tdata, prev_d);
            end
            instr_tready = 1'($urandom_range(0, 1));
            if (instr_tvalid && instr_tready) begin
                chk("stall_order", instr_tdata, base + W'(beats % 4));
                beats++;
            end
            prev_v = instr_tvalid;
            prev_r = instr_tready;
            prev_d = instr_tdata;
            tick();
            cyc++;
        end
        chk("stall_beats", beats, 12);
        chk("stall_no_extra", instr_tvalid, 0);
        chk("stall_done", done, 1);
        chk("stall_loop_cnt", loop_cnt, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        base = 32'hC000_0000;
        load(3, base);
        instr_tready = 1'b1;
        pulse_start(0);
        beats = 0;
        cyc = 0;
        bad = 0;
        while (beats < 1000 && cyc < 1100) begin
            if (instr_tvalid) begin
                if (instr_tdata !== base + W'(beats % 3)) bad++;
                beats++;
            end
            if (beats == 1000) stop = 1'b1;
            tick();
            cyc++;
        end
        stop = 1'b0;
        chk("loop0_beats", beats, 1000);
        chk("loop0_data_errs", bad, 0);
        chk("loop0_tvalid_off", instr_tvalid, 0);
        chk("loop0_busy", busy, 0);
        chk("loop0_done", done, 0);
        chk("loop0_loop_cnt", loop_cnt, 333);
        chk("loop0_armed_tready", prog_tready, 0);
        tick();
        tick();
        chk("loop0_still_off", instr_tvalid, 0);

        start = 1'b1;
        stop  = 1'b1;
        loops = 1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("startstop_busy", busy, 1);
        tick();
        beats = 0;
        while (instr_tvalid && beats < 20) begin
            beats++;
            tick();
        end
        chk("startstop_beats", beats, 3);
        chk("startstop_done", done, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        load(2, 32'hD000_0000);
        start = 1'b1;
        clear = 1'b1;
        tick();
        start = 1'b0;
        clear = 1'b0;
        chk("clrstart_busy", busy, 0);
        chk("clrstart_len", prog_len, 0);
        chk("clrstart_tready", prog_tready, 1);
        pulse_start(1);
        chk("load_start_ignored", busy, 0);

        base = 32'hE000_0000;
        load(3, base);
        instr_tready = 1'b0;
        pulse_start(1);
        tick();
        chk("clrstall_valid", instr_tvalid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrstall_held_valid", instr_tvalid, 1);
        chk("clrstall_held_data", instr_tdata, base);
        chk("clrstall_busy", busy, 1);
        tick();
        chk("clrstall_held_valid2", instr_tvalid, 1);
        instr_tready = 1'b1;
        tick();
        chk("clrstall_tvalid_off", instr_tvalid, 0);
        chk("clrstall_len", prog_len, 0);
        chk("clrstall_busy_off", busy, 0);
        chk("clrstall_done", done, 0);
        chk("clrstall_prog_tready", prog_tready, 1);

        load(4, 32'hF000_0000);
        pulse_start(0);
        tick();
        chk("rstplay_valid", instr_tvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstplay_tvalid", instr_tvalid, 0);
        chk("rstplay_len", prog_len, 0);
        chk("rstplay_busy", busy, 0);
        chk("rstplay_prog_tready", prog_tready, 0);
        tick();
        rst_n = 1'b1;
        chk("rstplay_rel_low", prog_tready, 0);
        tick();
        chk("rstplay_rel_high", prog_tready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
